// File: rtl/cplx_frame_accum_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cplx_frame_accum_if                                              |
// | Product-stream in / frame-sum out bundle for cplx_frame_accum.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface cplx_frame_accum_if #(
  parameter int PWIDTH = 37,
  parameter int CWIDTH = 8
);
  localparam int AWIDTH_OUT = PWIDTH + CWIDTH;

  logic                         in_valid;
  logic signed [PWIDTH-1:0]     pr_in;
  logic signed [PWIDTH-1:0]     pi_in;
  logic        [CWIDTH-1:0]     frame_len;
  logic                         clear;
  logic signed [AWIDTH_OUT-1:0] sum_r;
  logic signed [AWIDTH_OUT-1:0] sum_i;
  logic                         sum_valid;
  logic                         busy;

  modport master (
    output in_valid, pr_in, pi_in, frame_len, clear,
    input  sum_r, sum_i, sum_valid, busy
  );

  modport slave (
    input  in_valid, pr_in, pi_in, frame_len, clear,
    output sum_r, sum_i, sum_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/cplx_frame_accum.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cplx_frame_accum                                                 |
// | Sums a programmable number of complex products into one sum.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module cplx_frame_accum #(
  parameter int PWIDTH = 37,
  parameter int CWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cplx_frame_accum_if.slave    bus
);
  localparam int AWIDTH_OUT = PWIDTH + CWIDTH;

  localparam logic [0:0]        ST_IDLE = 1'b0;
  localparam logic [0:0]        ST_ACC  = 1'b1;
  localparam logic [CWIDTH-1:0] LEN_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

  logic [0:0]                   state_q, state_d;
  logic [CWIDTH-1:0]            cnt_q, cnt_d;
  logic [CWIDTH-1:0]            len_q, len_d;
  logic signed [AWIDTH_OUT-1:0] acc_r_q, acc_r_d;
  logic signed [AWIDTH_OUT-1:0] acc_i_q, acc_i_d;
  logic signed [AWIDTH_OUT-1:0] sum_r_q, sum_r_d;
  logic signed [AWIDTH_OUT-1:0] sum_i_q, sum_i_d;
  logic                         sum_valid_q, sum_valid_d;

  logic signed [AWIDTH_OUT-1:0] ext_r, ext_i;
  logic [CWIDTH-1:0]            len_eff;
  logic [CWIDTH-1:0]            cnt_inc;
  logic                         frame_done;

  assign ext_r      = {{CWIDTH{bus.pr_in[PWIDTH-1]}}, bus.pr_in};
  assign ext_i      = {{CWIDTH{bus.pi_in[PWIDTH-1]}}, bus.pi_in};
  assign len_eff    = (bus.frame_len == '0) ? LEN_ONE : bus.frame_len;
  assign cnt_inc    = cnt_q + LEN_ONE;
  assign frame_done = (cnt_inc == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // clear outranks a coincident sample; in IDLE it has nothing to discard
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else if (bus.in_valid) begin
      case (state_q)
        ST_IDLE: if (len_eff != LEN_ONE) state_d = ST_ACC;
        ST_ACC:  if (frame_done)         state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_r_d     = acc_r_q;
    acc_i_d     = acc_i_q;
    sum_r_d     = sum_r_q;
    sum_i_d     = sum_i_q;
    sum_valid_d = 1'b0;
    if (bus.clear) begin
      cnt_d   = '0;
      acc_r_d = '0;
      acc_i_d = '0;
    end else if (bus.in_valid) begin
      case (state_q)
        ST_IDLE: begin
          len_d = len_eff;
          if (len_eff == LEN_ONE) begin
            sum_r_d     = ext_r;
            sum_i_d     = ext_i;
            sum_valid_d = 1'b1;
          end else begin
            acc_r_d = ext_r;
            acc_i_d = ext_i;
            cnt_d   = LEN_ONE;
          end
        end
        ST_ACC: begin
          if (frame_done) begin
            sum_r_d     = acc_r_q + ext_r;
            sum_i_d     = acc_i_q + ext_i;
            sum_valid_d = 1'b1;
            acc_r_d     = '0;
            acc_i_d     = '0;
            cnt_d       = '0;
          end else begin
            acc_r_d = acc_r_q + ext_r;
            acc_i_d = acc_i_q + ext_i;
            cnt_d   = cnt_inc;
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      len_q       <= LEN_ONE;
      acc_r_q     <= '0;
      acc_i_q     <= '0;
      sum_r_q     <= '0;
      sum_i_q     <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_r_q     <= acc_r_d;
      acc_i_q     <= acc_i_d;
      sum_r_q     <= sum_r_d;
      sum_i_q     <= sum_i_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  always_comb begin
    bus.sum_r     = sum_r_q;
    bus.sum_i     = sum_i_q;
    bus.sum_valid = sum_valid_q;
    bus.busy      = (state_q == ST_ACC);
  end
endmodule
`default_nettype wire
